aes128_iter_core: RTL and testbench

Folded, parametrised AES-128 encryption engine and successor to the fixed 10-stage unrolled top. It applies UNROLL rounds per clock with on-the-fly key expansion, uses valid/ready handshakes on input and output, and adds a CTR mode with an internal 128-bit counter. It sits behind the AXI/BRAM wrapper in place of the unrolled core when area matters more than throughput.

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/aes_round_step.sv | 59 +++++
 rtl/aes128_iter_core.sv | 141 ++++++++++++++
 tb/tb_aes128_iter_core.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aes_pkg : shared AES-128 tables, GF helpers and FSM state type    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
package aes_pkg;

  localparam int MIX_BYPASS_ROUND = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } core_state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Indexed by absolute round number; entries 0 and 11..15 are never used.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // FIPS-197 byte 0 lives in bits [127:120].
  function automatic logic [7:0] get_byte(input logic [127:0] blk, input int idx);
    return blk[127-8*idx -: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aes_round_step : one combinational AES round plus key expansion   |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module aes_round_step
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] key_in,
  input  logic [3:0]   round,
  output logic [127:0] state_out,
  output logic [127:0] key_out
);

  logic [31:0]  w_prev [0:3];
  logic [31:0]  w_next [0:3];
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [127:0] sub_bytes;
  logic [127:0] shift_rows;
  logic [127:0] mix_cols;
  logic [7:0]   a0, a1, a2, a3;

  always_comb begin
    for (int i = 0; i < 4; i++) w_prev[i] = key_in[127-32*i -: 32];
    rot_word = {w_prev[3][23:0], w_prev[3][31:24]};
    sub_word = {SBOX[rot_word[31:24]], SBOX[rot_word[23:16]],
                SBOX[rot_word[15:8]],  SBOX[rot_word[7:0]]};
    w_next[0] = w_prev[0] ^ sub_word ^ {RCON[round], 24'h0};
    for (int i = 1; i < 4; i++) w_next[i] = w_prev[i] ^ w_next[i-1];
    key_out = {w_next[0], w_next[1], w_next[2], w_next[3]};

    sub_bytes  = '0;
    shift_rows = '0;
    mix_cols   = '0;
    for (int i = 0; i < 16; i++) sub_bytes[127-8*i -: 8] = SBOX[get_byte(state_in, i)];
    // Byte i sits in row i%4, column i/4; row r rotates left by r columns.
    for (int i = 0; i < 16; i++)
      shift_rows[127-8*i -: 8] = get_byte(sub_bytes, (i % 4) + 4 * (((i / 4) + (i % 4)) % 4));

    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = get_byte(shift_rows, 4*c);
      a1 = get_byte(shift_rows, 4*c + 1);
      a2 = get_byte(shift_rows, 4*c + 2);
      a3 = get_byte(shift_rows, 4*c + 3);
      mix_cols[127-32*c -: 32] = {
        gf_mul2(a0) ^ gf_mul2(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ gf_mul2(a1) ^ gf_mul2(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul2(a3) ^ a3,
        gf_mul2(a0) ^ a0 ^ a1 ^ a2 ^ gf_mul2(a3)};
    end

    state_out = ((round == 4'(MIX_BYPASS_ROUND)) ? shift_rows : mix_cols) ^ key_out;
  end

endmodule
`default_nettype wire

// File: rtl/aes128_iter_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aes128_iter_core : folded AES-128 encrypt, UNROLL rounds/clock,    |
// | ECB or CTR with internal 128-bit counter.  rev 1.0                 |
// +------------------------------------------------------------------+
module aes128_iter_core
  import aes_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter int CTR_EN = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  input  logic         mode,
  input  logic         ctr_load,
  input  logic [127:0] ctr_init,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
    $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
  end

  localparam logic [3:0] UNROLL_W = 4'(UNROLL);

  core_state_e  state_q, state_d;
  logic [127:0] blk_q, blk_d, rkey_q, rkey_d, data_q, data_d, ctr_q, ctr_d;
  logic [127:0] out_data_q, out_data_d, ctr_cur;
  logic [3:0]   rnd_q, rnd_d;
  logic         mode_q, mode_d, mode_eff;
  logic         out_valid_q, out_valid_d, in_ready_q, in_ready_d, busy_q, busy_d;

  logic [127:0] st_chain  [0:UNROLL];
  logic [127:0] key_chain [0:UNROLL];

  assign st_chain[0]  = blk_q;
  assign key_chain[0] = rkey_q;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    aes_round_step u_step (
      .state_in  (st_chain[g]),
      .key_in    (key_chain[g]),
      .round     (rnd_q + 4'(g + 1)),
      .state_out (st_chain[g+1]),
      .key_out   (key_chain[g+1])
    );
  end

  assign mode_eff = (CTR_EN != 0) && mode;
  // A load coinciding with an accept feeds the block directly.
  assign ctr_cur  = ctr_load ? ctr_init : ctr_q;

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    rkey_d      = rkey_q;
    rnd_d       = rnd_q;
    mode_d      = mode_q;
    data_d      = data_q;
    ctr_d       = ctr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (CTR_EN != 0 && ctr_load) ctr_d = ctr_init;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          mode_d  = mode_eff;
          data_d  = in_data;
          rkey_d  = in_key;
          rnd_d   = '0;
          blk_d   = (mode_eff ? ctr_cur : in_data) ^ in_key;
          if (mode_eff) ctr_d = ctr_cur + 128'd1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        blk_d  = st_chain[UNROLL];
        rkey_d = key_chain[UNROLL];
        rnd_d  = rnd_q + UNROLL_W;
        if ((rnd_q + UNROLL_W) == 4'd10) begin
          out_data_d  = st_chain[UNROLL] ^ (mode_q ? data_q : 128'd0);
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      blk_q       <= '0;
      rkey_q      <= '0;
      rnd_q       <= '0;
      mode_q      <= 1'b0;
      data_q      <= '0;
      ctr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      rkey_q      <= rkey_d;
      rnd_q       <= rnd_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
      ctr_q       <= ctr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_aes128_iter_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_aes128_iter_core : directed FIPS-197 / CTR / reset checks with  |
// | an independent AES reference for counter blocks.  rev 1.0          |
// +------------------------------------------------------------------+
module tb_aes128_iter_core;

  logic clk, reset, in_valid, in_valid_m, mode, ctr_load, out_ready;
  logic [127:0] in_data, in_key, ctr_init;
  logic in_ready1, out_valid1, busy1;
  logic in_ready2, out_valid2, busy2;
  logic in_ready5, out_valid5, busy5;
  logic in_ready10, out_valid10, busy10;
  logic [127:0] out_data1, out_data2, out_data5, out_data10;
  int total, bad;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes128_iter_core #(.UNROLL(1), .CTR_EN(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_key(in_key), .mode(mode), .ctr_load(ctr_load),
    .ctr_init(ctr_init), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .busy(busy1));
  aes128_iter_core #(.UNROLL(2), .CTR_EN(1)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid_m), .in_ready(in_ready2),
    .in_data(in_data), .in_key(in_key), .mode(mode), .ctr_load(ctr_load),
    .ctr_init(ctr_init), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .busy(busy2));
  aes128_iter_core #(.UNROLL(5), .CTR_EN(1)) u5 (
    .clk(clk), .reset(reset), .in_valid(in_valid_m), .in_ready(in_ready5),
    .in_data(in_data), .in_key(in_key), .mode(mode), .ctr_load(ctr_load),
    .ctr_init(ctr_init), .out_valid(out_valid5), .out_ready(out_ready),
    .out_data(out_data5), .busy(busy5));
  aes128_iter_core #(.UNROLL(10), .CTR_EN(1)) u10 (
    .clk(clk), .reset(reset), .in_valid(in_valid_m), .in_ready(in_ready10),
    .in_data(in_data), .in_key(in_key), .mode(mode), .ctr_load(ctr_load),
    .ctr_init(ctr_init), .out_valid(out_valid10), .out_ready(out_ready),
    .out_data(out_data10), .busy(busy10));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference AES: S-box derived from GF(2^8) inverse plus affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, a);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] k [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, b0, b1, b2, b3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127-8*i -: 8];
      s[i] = pt[127-8*i -: 8] ^ k[i];
    end
    rc = 8'h01;
    for (int rd = 1; rd <= 10; rd++) begin
      tmp[0] = sbox_m(k[13]) ^ rc;
      tmp[1] = sbox_m(k[14]);
      tmp[2] = sbox_m(k[15]);
      tmp[3] = sbox_m(k[12]);
      for (int i = 0; i < 16; i++) begin
        if (i < 4) k[i] = k[i] ^ tmp[i];
        else       k[i] = k[i] ^ k[i-4];
      end
      rc = gmul(rc, 8'h02);
      for (int i = 0; i < 16; i++) t[i] = sbox_m(s[i]);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r+4*c] = t[r + 4*((c+r)%4)];
      if (rd != 10) begin
        for (int c = 0; c < 4; c++) begin
          b0 = s[4*c]; b1 = s[4*c+1]; b2 = s[4*c+2]; b3 = s[4*c+3];
          s[4*c]   = gmul(b0, 8'h02) ^ gmul(b1, 8'h03) ^ b2 ^ b3;
          s[4*c+1] = b0 ^ gmul(b1, 8'h02) ^ gmul(b2, 8'h03) ^ b3;
          s[4*c+2] = b0 ^ b1 ^ gmul(b2, 8'h02) ^ gmul(b3, 8'h03);
          s[4*c+3] = gmul(b0, 8'h03) ^ b1 ^ b2 ^ gmul(b3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers one block to u1, then checks latency and result.
  task automatic run_block(input string tag, input logic [127:0] d, input logic [127:0] k,
                           input logic m, input logic ld, input logic [127:0] ldv,
                           input logic [127:0] exp_out);
    int w, lat;
    w = 0;
    while (in_ready1 !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    check({tag, "_ready"}, in_ready1, 1);
    in_data = d; in_key = k; mode = m; ctr_load = ld; ctr_init = ldv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; ctr_load = 1'b0;
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end
    while (out_valid1 !== 1'b1 && lat < 40);
    check({tag, "_lat"}, lat, 10);
    check({tag, "_data"}, out_data1, exp_out);
  endtask

  initial begin
    int l2, l5, l10, lat;
    logic [127:0] d2, d5, d10, hold, exp;
    logic seen;
    total = 0; bad = 0;
    reset = 1'b0; in_valid = 1'b0; in_valid_m = 1'b0; mode = 1'b0; ctr_load = 1'b0;
    out_ready = 1'b1; in_data = '0; in_key = '0; ctr_init = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready1, 0);
    check("rst_out_valid", out_valid1, 0);
    check("rst_out_data", out_data1, 0);
    check("rst_busy", busy1, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready1, 1);

    // App. B ECB, UNROLL=1
    run_block("appb", PT_B, KEY_B, 1'b0, 1'b0, '0, CT_B);

    // App. C.1 on all unroll factors at once
    @(negedge clk); @(negedge clk);
    in_data = PT_C; in_key = KEY_C; mode = 1'b0; in_valid = 1'b1; in_valid_m = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid_m = 1'b0;
    l2 = 0; l5 = 0; l10 = 0; lat = 0; d2 = '0; d5 = '0; d10 = '0; hold = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid1 === 1'b1 && lat == 0) begin lat = cyc; hold = out_data1; end
      if (out_valid2 === 1'b1 && l2 == 0) begin l2 = cyc; d2 = out_data2; end
      if (out_valid5 === 1'b1 && l5 == 0) begin l5 = cyc; d5 = out_data5; end
      if (out_valid10 === 1'b1 && l10 == 0) begin l10 = cyc; d10 = out_data10; end
    end
    check("c1_u1_lat", lat, 10);
    check("c1_u1_data", hold, CT_C);
    check("c1_u2_lat", l2, 5);
    check("c1_u2_data", d2, CT_C);
    check("c1_u5_lat", l5, 2);
    check("c1_u5_data", d5, CT_C);
    check("c1_u10_lat", l10, 1);
    check("c1_u10_data", d10, CT_C);

    // Back-pressure: result held, nothing accepted while DONE
    out_ready = 1'b0;
    run_block("bp", PT_B, KEY_B, 1'b0, 1'b0, '0, CT_B);
    in_valid = 1'b1; in_data = PT_C; in_key = KEY_C;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("bp_hold_data", out_data1, CT_B);
      check("bp_hold_ready", in_ready1, 0);
      check("bp_hold_valid", out_valid1, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_ready", in_ready1, 1);
    check("bp_rel_valid", out_valid1, 0);

    // CTR with counter wrap
    ctr_load = 1'b1; ctr_init = '1;
    @(negedge clk);
    ctr_load = 1'b0; ctr_init = '0;
    hold = 128'h00112233445566778899aabbccddeeff;
    run_block("ctr1", hold, KEY_B, 1'b1, 1'b0, '0, hold ^ aes_model(KEY_B, '1));
    hold = 128'hdeadbeef0123456789abcdeffedcba98;
    exp = aes_model(KEY_B, '0);
    run_block("ctr2", hold, KEY_B, 1'b1, 1'b0, '0, hold ^ exp);
    check("ctr2_recover", out_data1 ^ hold, exp);

    // Reset asserted after round 4
    @(negedge clk); @(negedge clk);
    in_data = PT_B; in_key = KEY_B; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", out_valid1, 0);
    check("mid_rst_busy", busy1, 0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid1 === 1'b1) seen = 1'b1;
    end
    check("mid_rst_no_out", seen, 0);
    check("mid_rst_idle", in_ready1, 1);
    run_block("post_rst", PT_B, KEY_B, 1'b0, 1'b0, '0, CT_B);

    // ctr_load coinciding with a CTR accept
    hold = 128'h0f0e0d0c0b0a09080706050403020100;
    run_block("ld_acc", hold, KEY_B, 1'b1, 1'b1, 128'h5, hold ^ aes_model(KEY_B, 128'h5));
    hold = 128'h55aa55aa55aa55aa55aa55aa55aa55aa;
    run_block("after_ld", hold, KEY_B, 1'b1, 1'b0, '0, hold ^ aes_model(KEY_B, 128'h6));

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
